// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the stage control-path front end: header layout,
// FSM encoding, config target ids and a saturating counter helper.
package stage_ctrl_pkg;

  localparam int HDR_MAGIC_LSB = 0;
  localparam int HDR_MAGIC_W   = 16;
  localparam int HDR_DST_LSB   = 16;
  localparam int HDR_DST_W     = 5;
  localparam int HDR_TGT_LSB   = 24;
  localparam int HDR_TGT_W     = 4;
  localparam int HDR_ADDR_LSB  = 32;
  localparam int HDR_ADDR_W    = 16;
  localparam int HDR_CNT_LSB   = 48;
  localparam int HDR_CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_CFG,
    ST_DROP
  } state_t;

  localparam logic [HDR_TGT_W-1:0] TGT_KEY_OFF  = 4'd0;
  localparam logic [HDR_TGT_W-1:0] TGT_KEY_MASK = 4'd1;
  localparam logic [HDR_TGT_W-1:0] TGT_LOOKUP   = 4'd2;
  localparam logic [HDR_TGT_W-1:0] TGT_ACTION   = 4'd3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stage_ctrl_hdr_decode.sv
// Combinational split of a control header beat into the fields the
// stage FSM needs, with the magic/destination/target checks pre-evaluated.
module stage_ctrl_hdr_decode
  import stage_ctrl_pkg::*;
#(
  parameter int          STAGE_ID       = 0,
  parameter int          NUM_TARGETS    = 4,
  parameter int          CFG_ADDR_WIDTH = 5,
  parameter logic [15:0] CTL_MAGIC      = 16'hF2F1
) (
  input  logic [63:0]               hdr,
  output logic                      magic_ok,
  output logic                      for_me,
  output logic                      target_ok,
  output logic [HDR_TGT_W-1:0]      target,
  output logic [CFG_ADDR_WIDTH-1:0] addr,
  output logic [HDR_CNT_W-1:0]      count
);

  logic unused_hdr_bits;

  assign magic_ok  = (hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] == CTL_MAGIC);
  assign for_me    = (hdr[HDR_DST_LSB +: HDR_DST_W] == HDR_DST_W'(STAGE_ID));
  assign target    = hdr[HDR_TGT_LSB +: HDR_TGT_W];
  // One extra bit so that NUM_TARGETS=16 still compares correctly.
  assign target_ok = ({1'b0, target} < (HDR_TGT_W + 1)'(NUM_TARGETS));
  assign addr      = hdr[HDR_ADDR_LSB +: CFG_ADDR_WIDTH];
  assign count     = hdr[HDR_CNT_LSB +: HDR_CNT_W];

  assign unused_hdr_bits = ^{hdr[23:21], hdr[31:28], hdr[47:32]};

endmodule

// File: rtl/stage_ctrl_cfg.sv
// RMT stage control front end: forwards foreign control packets with one
// cycle latency and turns packets for this stage into config-RAM writes.
module stage_ctrl_cfg
  import stage_ctrl_pkg::*;
#(
  parameter int          STAGE_ID             = 0,
  parameter int          C_S_AXIS_DATA_WIDTH  = 256,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          NUM_TARGETS          = 4,
  parameter int          CFG_ADDR_WIDTH       = 5,
  parameter int          CFG_DATA_WIDTH       = 256,
  parameter logic [15:0] CTL_MAGIC            = 16'hF2F1
) (
  input  logic                              axis_clk,
  input  logic                              areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast,
  output logic [NUM_TARGETS-1:0]            cfg_wr_en,
  output logic [CFG_ADDR_WIDTH-1:0]         cfg_wr_addr,
  output logic [CFG_DATA_WIDTH-1:0]         cfg_wr_data,
  output logic                              cfg_busy,
  output logic [15:0]                       cfg_pkt_cnt,
  output logic [15:0]                       cfg_err_cnt
);

  state_t                    state;
  logic [HDR_TGT_W-1:0]      tgt_q;
  logic [CFG_ADDR_WIDTH-1:0] addr_q;
  logic [HDR_CNT_W-1:0]      rem_q;

  logic                      hdr_magic_ok;
  logic                      hdr_for_me;
  logic                      hdr_target_ok;
  logic [HDR_TGT_W-1:0]      hdr_target;
  logic [CFG_ADDR_WIDTH-1:0] hdr_addr;
  logic [HDR_CNT_W-1:0]      hdr_count;

  stage_ctrl_hdr_decode #(
    .STAGE_ID       (STAGE_ID),
    .NUM_TARGETS    (NUM_TARGETS),
    .CFG_ADDR_WIDTH (CFG_ADDR_WIDTH),
    .CTL_MAGIC      (CTL_MAGIC)
  ) u_hdr_decode (
    .hdr       (c_s_axis_tdata[63:0]),
    .magic_ok  (hdr_magic_ok),
    .for_me    (hdr_for_me),
    .target_ok (hdr_target_ok),
    .target    (hdr_target),
    .addr      (hdr_addr),
    .count     (hdr_count)
  );

  // Busy covers the accepting header cycle too, so it cannot be a plain register.
  assign cfg_busy = !areset &&
                    ((state == ST_CFG) ||
                     ((state == ST_IDLE) && c_s_axis_tvalid && hdr_magic_ok &&
                      hdr_for_me && hdr_target_ok && !c_s_axis_tlast));

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state           <= ST_IDLE;
      tgt_q           <= '0;
      addr_q          <= '0;
      rem_q           <= '0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      cfg_wr_en       <= '0;
      cfg_wr_addr     <= '0;
      cfg_wr_data     <= '0;
      cfg_pkt_cnt     <= '0;
      cfg_err_cnt     <= '0;
    end else begin
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
      cfg_wr_en       <= '0;
      if (c_s_axis_tvalid) begin
        case (state)
          ST_IDLE: begin
            if (!hdr_magic_ok) begin
              cfg_err_cnt <= sat_inc(cfg_err_cnt);
              if (!c_s_axis_tlast) state <= ST_DROP;
            end else if (!hdr_for_me) begin
              c_m_axis_tdata  <= c_s_axis_tdata;
              c_m_axis_tuser  <= c_s_axis_tuser;
              c_m_axis_tkeep  <= c_s_axis_tkeep;
              c_m_axis_tvalid <= 1'b1;
              c_m_axis_tlast  <= c_s_axis_tlast;
              if (!c_s_axis_tlast) state <= ST_FWD;
            end else if (!hdr_target_ok) begin
              cfg_err_cnt <= sat_inc(cfg_err_cnt);
              if (!c_s_axis_tlast) state <= ST_DROP;
            end else begin
              tgt_q  <= hdr_target;
              addr_q <= hdr_addr;
              rem_q  <= hdr_count;
              if (c_s_axis_tlast) begin
                if (hdr_count == '0) cfg_pkt_cnt <= sat_inc(cfg_pkt_cnt);
                else                 cfg_err_cnt <= sat_inc(cfg_err_cnt);
              end else begin
                state <= ST_CFG;
              end
            end
          end
          ST_FWD: begin
            c_m_axis_tdata  <= c_s_axis_tdata;
            c_m_axis_tuser  <= c_s_axis_tuser;
            c_m_axis_tkeep  <= c_s_axis_tkeep;
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= c_s_axis_tlast;
            if (c_s_axis_tlast) state <= ST_IDLE;
          end
          ST_CFG: begin
            if (rem_q != '0) begin
              cfg_wr_en   <= NUM_TARGETS'(1) << tgt_q;
              cfg_wr_addr <= addr_q;
              cfg_wr_data <= c_s_axis_tdata[CFG_DATA_WIDTH-1:0];
              addr_q      <= addr_q + CFG_ADDR_WIDTH'(1);
              rem_q       <= rem_q - HDR_CNT_W'(1);
            end
            // Once rem_q hits zero it stays there, so a dropped beat can only
            // be followed by more drops; good means this last beat wrote the Nth entry.
            if (c_s_axis_tlast) begin
              state <= ST_IDLE;
              if (rem_q == HDR_CNT_W'(1)) cfg_pkt_cnt <= sat_inc(cfg_pkt_cnt);
              else                        cfg_err_cnt <= sat_inc(cfg_err_cnt);
            end
          end
          ST_DROP: begin
            if (c_s_axis_tlast) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stage_ctrl_cfg.sv
// Scoreboard bench for stage_ctrl_cfg: packet-level reference model pushes
// expected forwards/writes; a negedge monitor pops and compares them.
module tb_stage_ctrl_cfg;
  import stage_ctrl_pkg::*;

  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int KW  = DW / 8;
  localparam int NT  = 4;
  localparam int AW  = 5;
  localparam int CW  = 256;
  localparam int SID = 0;
  localparam logic [15:0] MAGIC = 16'hF2F1;

  logic          axis_clk = 1'b0;
  logic          areset;
  logic [DW-1:0] c_s_axis_tdata;
  logic [UW-1:0] c_s_axis_tuser;
  logic [KW-1:0] c_s_axis_tkeep;
  logic          c_s_axis_tvalid;
  logic          c_s_axis_tlast;
  logic [DW-1:0] c_m_axis_tdata;
  logic [UW-1:0] c_m_axis_tuser;
  logic [KW-1:0] c_m_axis_tkeep;
  logic          c_m_axis_tvalid;
  logic          c_m_axis_tlast;
  logic [NT-1:0] cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [CW-1:0] cfg_wr_data;
  logic          cfg_busy;
  logic [15:0]   cfg_pkt_cnt;
  logic [15:0]   cfg_err_cnt;

  always #5 axis_clk = ~axis_clk;

  stage_ctrl_cfg #(
    .STAGE_ID             (SID),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .NUM_TARGETS          (NT),
    .CFG_ADDR_WIDTH       (AW),
    .CFG_DATA_WIDTH       (CW),
    .CTL_MAGIC            (MAGIC)
  ) dut (
    .axis_clk        (axis_clk),
    .areset          (areset),
    .c_s_axis_tdata  (c_s_axis_tdata),
    .c_s_axis_tuser  (c_s_axis_tuser),
    .c_s_axis_tkeep  (c_s_axis_tkeep),
    .c_s_axis_tvalid (c_s_axis_tvalid),
    .c_s_axis_tlast  (c_s_axis_tlast),
    .c_m_axis_tdata  (c_m_axis_tdata),
    .c_m_axis_tuser  (c_m_axis_tuser),
    .c_m_axis_tkeep  (c_m_axis_tkeep),
    .c_m_axis_tvalid (c_m_axis_tvalid),
    .c_m_axis_tlast  (c_m_axis_tlast),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_data     (cfg_wr_data),
    .cfg_busy        (cfg_busy),
    .cfg_pkt_cnt     (cfg_pkt_cnt),
    .cfg_err_cnt     (cfg_err_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
    int            cyc;
  } fwd_t;

  typedef struct {
    logic [NT-1:0] en;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    int            cyc;
  } wr_t;

  fwd_t          fwd_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] data_buf[$];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            exp_pkt = 0;
  int            exp_err = 0;
  logic          busy_exp = 1'b0;

  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] mkHdr(input logic [15:0] mg, input logic [4:0] dst,
                                          input logic [3:0] tgt, input logic [15:0] addr,
                                          input logic [15:0] n);
    logic [DW-1:0] h;
    h = rand256();
    h[15:0]  = mg;
    h[20:16] = dst;
    h[27:24] = tgt;
    h[47:32] = addr;
    h[63:48] = n;
    return h;
  endfunction

  // Monitor: busy every cycle, plus forwarded beats and writes against the queues.
  always @(negedge axis_clk) begin
    fwd_t fe;
    wr_t  we;
    checkOutput("busy", 256'(cfg_busy), 256'(busy_exp));
    if (c_m_axis_tvalid === 1'b1) begin
      if (fwd_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL fwd_unexpected: got tdata %0h, expected no forwarded beat", c_m_axis_tdata);
      end else begin
        fe = fwd_q.pop_front();
        checkOutput("fwd_tdata", c_m_axis_tdata, fe.data);
        checkOutput("fwd_tuser", 256'(c_m_axis_tuser), 256'(fe.user));
        checkOutput("fwd_tkeep", 256'(c_m_axis_tkeep), 256'(fe.keep));
        checkOutput("fwd_tlast", 256'(c_m_axis_tlast), 256'(fe.last));
        checkOutput("fwd_cycle", 256'(cyc), 256'(fe.cyc));
      end
    end
    if (cfg_wr_en !== '0) begin
      if (wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL wr_unexpected: got en %0h addr %0d, expected no write", cfg_wr_en, cfg_wr_addr);
      end else begin
        we = wr_q.pop_front();
        checkOutput("wr_en", 256'(cfg_wr_en), 256'(we.en));
        checkOutput("wr_addr", 256'(cfg_wr_addr), 256'(we.addr));
        checkOutput("wr_data", 256'(cfg_wr_data), 256'(we.data));
        checkOutput("wr_cycle", 256'(cyc), 256'(we.cyc));
      end
    end
  end

  task automatic driveBeat(input logic v, input logic [DW-1:0] d, input logic l, input logic b);
    @(posedge axis_clk);
    #1;
    areset          = 1'b0;
    c_s_axis_tvalid = v;
    c_s_axis_tdata  = d;
    c_s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    c_s_axis_tkeep  = $urandom;
    c_s_axis_tlast  = l;
    busy_exp        = b;
  endtask

  task automatic driveReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge axis_clk);
      #1;
      areset          = 1'b1;
      c_s_axis_tvalid = 1'b0;
      busy_exp        = 1'b0;
    end
    exp_pkt = 0;
    exp_err = 0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_tvalid", 256'(c_m_axis_tvalid), 256'(0));
    checkOutput("rst_tlast", 256'(c_m_axis_tlast), 256'(0));
    checkOutput("rst_tdata", c_m_axis_tdata, 256'(0));
    checkOutput("rst_wr_en", 256'(cfg_wr_en), 256'(0));
    checkOutput("rst_wr_addr", 256'(cfg_wr_addr), 256'(0));
    checkOutput("rst_wr_data", 256'(cfg_wr_data), 256'(0));
    checkOutput("rst_busy", 256'(cfg_busy), 256'(0));
    checkOutput("rst_pkt_cnt", 256'(cfg_pkt_cnt), 256'(0));
    checkOutput("rst_err_cnt", 256'(cfg_err_cnt), 256'(0));
  endtask

  // Sends header + data_buf as one packet; the model works on whole packets.
  task automatic applyStimulus(input logic [DW-1:0] hdr, input int gap, input bit rand_gap);
    int            nd       = data_buf.size();
    bit            magic_ok = (hdr[15:0] == MAGIC);
    bit            to_me    = (int'(hdr[20:16]) == SID);
    bit            tgt_ok   = (int'(hdr[27:24]) < NT);
    int            tgt      = int'(hdr[27:24]);
    int            n        = int'(hdr[63:48]);
    int            base     = int'(hdr[47:32]);
    bit            fwd_all  = magic_ok && !to_me;
    bit            cfg      = magic_ok && to_me && tgt_ok;
    int            nwr      = cfg ? ((n < nd) ? n : nd) : 0;
    bit            busy_pkt = cfg && (nd > 0);
    logic [DW-1:0] beat;
    bit            last;
    int            g;
    fwd_t          fe;
    wr_t           we;
    for (int i = 0; i <= nd; i++) begin
      beat = (i == 0) ? hdr : data_buf[i-1];
      last = (i == nd);
      driveBeat(1'b1, beat, last, busy_pkt);
      if (fwd_all) begin
        fe.data = beat;
        fe.user = c_s_axis_tuser;
        fe.keep = c_s_axis_tkeep;
        fe.last = last;
        fe.cyc  = cyc + 1;
        fwd_q.push_back(fe);
      end
      if (cfg && i >= 1 && (i - 1) < nwr) begin
        we.en       = '0;
        we.en[tgt]  = 1'b1;
        we.addr     = AW'((base + i - 1) % (1 << AW));
        we.data     = beat[CW-1:0];
        we.cyc      = cyc + 1;
        wr_q.push_back(we);
      end
      if (!last) begin
        g = rand_gap ? $urandom_range(gap, 0) : gap;
        for (int k = 0; k < g; k++) driveBeat(1'b0, rand256(), 1'($urandom), busy_pkt);
      end
    end
    if (!magic_ok)     exp_err++;
    else if (!to_me)   ;
    else if (!tgt_ok)  exp_err++;
    else if (nd == n)  exp_pkt++;
    else               exp_err++;
    driveBeat(1'b0, rand256(), 1'b0, 1'b0);
    driveBeat(1'b0, rand256(), 1'b0, 1'b0);
    @(negedge axis_clk);
    checkOutput("pkt_cnt", 256'(cfg_pkt_cnt), 256'(exp_pkt));
    checkOutput("err_cnt", 256'(cfg_err_cnt), 256'(exp_err));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            kind;
    int            n;
    int            nd;
    logic [4:0]    dst;
    logic [3:0]    tgt;
    logic [15:0]   mg;
    logic [DW-1:0] stale;
    wr_t           we;

    areset          = 1'b1;
    c_s_axis_tvalid = 1'b0;
    c_s_axis_tdata  = '0;
    c_s_axis_tuser  = '0;
    c_s_axis_tkeep  = '0;
    c_s_axis_tlast  = 1'b0;
    driveReset(3);
    @(negedge axis_clk);
    checkResetState();

    // Forward to stage 2: header + 2 data beats.
    data_buf = '{rand256(), rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd2, 4'd0, 16'd0, 16'd0), 0, 1'b0);

    // Burst of three into the action RAM.
    data_buf = '{256'hA, 256'hB, 256'hC};
    applyStimulus(mkHdr(MAGIC, 5'd0, TGT_ACTION, 16'd5, 16'd3), 0, 1'b0);

    // Address wrap from 30.
    data_buf = '{rand256(), rand256(), rand256(), rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd0, TGT_KEY_OFF, 16'd30, 16'd4), 0, 1'b0);

    // Long packet, short packet.
    data_buf = '{rand256(), rand256(), rand256(), rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd0, TGT_KEY_MASK, 16'd10, 16'd2), 0, 1'b0);
    data_buf = '{rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd0, TGT_LOOKUP, 16'd3, 16'd3), 0, 1'b0);

    // Bad magic and out-of-range target.
    data_buf = '{rand256()};
    applyStimulus(mkHdr(16'h1234, 5'd0, TGT_KEY_OFF, 16'd1, 16'd1), 0, 1'b0);
    data_buf = '{rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd0, 4'd7, 16'd1, 16'd1), 0, 1'b0);

    // Three idle cycles between every data beat.
    data_buf = '{rand256(), rand256(), rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd0, TGT_LOOKUP, 16'd12, 16'd3), 3, 1'b0);

    for (int p = 0; p < 150; p++) begin
      kind = $urandom_range(6, 0);
      n    = $urandom_range(6, 0);
      nd   = n;
      dst  = 5'(SID);
      tgt  = 4'($urandom_range(NT - 1, 0));
      mg   = MAGIC;
      case (kind)
        0: begin dst = 5'($urandom_range(31, 1)); nd = $urandom_range(4, 0); end
        3: nd = $urandom_range(6, 0);
        4: begin mg = 16'($urandom); if (mg == MAGIC) mg = ~mg; nd = $urandom_range(3, 0); end
        5: begin tgt = 4'($urandom_range(15, NT)); nd = $urandom_range(3, 0); end
        6: nd = n + $urandom_range(2, 1);
        default: nd = n;
      endcase
      data_buf.delete();
      for (int i = 0; i < nd; i++) data_buf.push_back(rand256());
      applyStimulus(mkHdr(mg, dst, tgt, 16'($urandom), 16'(n)), 2, 1'b1);
    end

    // Reset after the first of four writes.
    driveBeat(1'b1, mkHdr(MAGIC, 5'd0, TGT_KEY_MASK, 16'd2, 16'd4), 1'b0, 1'b1);
    stale = rand256();
    driveBeat(1'b1, stale, 1'b0, 1'b1);
    we.en      = '0;
    we.en[1]   = 1'b1;
    we.addr    = AW'(2);
    we.data    = stale[CW-1:0];
    we.cyc     = cyc + 1;
    wr_q.push_back(we);
    driveReset(1);
    driveBeat(1'b0, rand256(), 1'b0, 1'b0);
    @(negedge axis_clk);
    checkResetState();

    stale = rand256();
    stale[15:0] = 16'h5A5A;
    data_buf = '{rand256()};
    applyStimulus(stale, 0, 1'b0);
    data_buf = '{rand256(), rand256()};
    applyStimulus(mkHdr(MAGIC, 5'd0, TGT_ACTION, 16'd20, 16'd2), 0, 1'b0);

    repeat (3) driveBeat(1'b0, rand256(), 1'b0, 1'b0);
    @(negedge axis_clk);
    checkOutput("fwd_queue_left", 256'(fwd_q.size()), 256'(0));
    checkOutput("wr_queue_left", 256'(wr_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_ctrl_cfg.md
Name: stage_ctrl_cfg

Overview:
- Control-path front end of an RMT pipeline stage. It snoops the daisy-chained control AXI-Stream.
- Packets addressed to this stage are consumed and turned into single-entry config writes. The targets are key-offset RAM, key-mask RAM, lookup CAM and action RAM, selected by target id.
- All other packets are forwarded to the next stage with one cycle of latency.
- It generalises the stage's unconnected control hooks: target count, address width and data width are parameters. It adds magic-word framing, multi-entry bursts with auto-increment, error detection and status counters.

Parameters:
- STAGE_ID, 0, this stage's id (0-31).
- C_S_AXIS_DATA_WIDTH, 256, control tdata width (≥64).
- C_S_AXIS_TUSER_WIDTH, 128, control tuser width.
- NUM_TARGETS, 4, number of config targets (1-16).
- CFG_ADDR_WIDTH, 5, config address width (1-16).
- CFG_DATA_WIDTH, 256, config entry width (≤C_S_AXIS_DATA_WIDTH).
- CTL_MAGIC, 16'hF2F1, header magic value.

Ports:
- axis_clk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- c_s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  control stream in.
- c_s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH.
- c_s_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8.
- c_s_axis_tvalid  in  1.
- c_s_axis_tlast  in  1.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  same widths  forwarded stream.
- cfg_wr_en  out  NUM_TARGETS  one-hot write strobe.
- cfg_wr_addr  out  CFG_ADDR_WIDTH  write address.
- cfg_wr_data  out  CFG_DATA_WIDTH  write data.
- cfg_busy  out  1  high while a packet for this stage is in progress.
- cfg_pkt_cnt  out  16  count of good config packets (saturating).
- cfg_err_cnt  out  16  count of errored packets (saturating).

Behaviour:
- Header beat is the first valid beat in IDLE. Fields:
  - tdata[15:0] = magic.
  - [20:16] = dst stage.
  - [27:24] = target id.
  - [47:32] = base address; low CFG_ADDR_WIDTH bits are used.
  - [63:48] = entry count N.
- No tready exists; every beat with tvalid=1 is accepted. Beats with tvalid=0 are ignored in all states.
- FSM states: IDLE, FWD, CFG, DROP.
- IDLE, valid beat:
  - magic≠CTL_MAGIC → header is not forwarded; err_cnt++; go to DROP. If tlast=1, stay in IDLE instead.
  - dst≠STAGE_ID → forward the beat; go to FWD. If tlast=1, stay in IDLE.
  - dst=STAGE_ID and target≥NUM_TARGETS → err_cnt++; go to DROP. If tlast=1, stay in IDLE.
  - dst=STAGE_ID, valid target → latch target, address and N.
    - If tlast=1: N=0 → pkt_cnt++; N>0 → err_cnt++. Stay in IDLE.
    - If tlast=0: go to CFG.
- FWD: forward each beat; return to IDLE on tlast.
- CFG, each data beat:
  - If remaining>0: assert cfg_wr_en[target] for one cycle, with cfg_wr_data = tdata[CFG_DATA_WIDTH-1:0]. Then address+1 (wraps modulo 2^CFG_ADDR_WIDTH) and remaining−1.
  - If remaining=0: beat is dropped, not written.
  - On tlast, exactly one counter increments. If exactly N writes were issued and no beat was dropped → pkt_cnt++. Otherwise (short: fewer than N; long: extra beats) → err_cnt++. Return to IDLE.
- DROP: discard beats until tlast, then IDLE.
- Latency:
  - Forwarding: c_m_* is registered, one cycle after input; tkeep and tuser pass unchanged.
  - Config write: strobe is registered, one cycle after the data beat.
  - Counters update one cycle after tlast.
- Consumed beats produce c_m_axis_tvalid=0.
- cfg_busy is 1 in CFG, and in the cycle a header for this stage is accepted with tlast=0.
- Both counters saturate at 16'hFFFF.
- Reset values:
  - All outputs are 0, including c_m_axis_tvalid, cfg_wr_en, cfg_busy and both counters.
  - FSM returns to IDLE.
  - Reset mid-packet: the next valid beat is parsed as a header. Leftover data normally fails the magic check and goes to DROP, so no spurious write occurs except on a magic collision. No write or forward in flight survives reset.

Decomposition:
- Package stage_ctrl_pkg holds:
  - header field bit offsets and widths;
  - the state encoding;
  - target id constants: KEY_OFF=0, KEY_MASK=1, LOOKUP=2, ACTION=3.
- One natural sub-module: stage_ctrl_hdr_decode. It is combinational: it splits the header beat into magic_ok, for_me, target_ok, addr and count.
- FSM, registered forward path and counters stay in the top level.

Test Plan:
- Forward: 3-beat packet with dst=2 at STAGE_ID=0 → identical 3 beats on c_m one cycle later, tlast on beat 3; no cfg_wr_en; counters stay 0.
- Burst write: header dst=0, target=3, addr=5, N=3, then 3 data beats 0xA, 0xB, 0xC (last) → cfg_wr_en=4'b1000 at addr 5, 6, 7 with data A, B, C; pkt_cnt=1; nothing on c_m.
- Wrap and length errors, CFG_ADDR_WIDTH=5:
  - addr=30, N=4 with 4 beats → writes to addresses 30, 31, 0, 1.
  - N=2 with 4 data beats → 2 writes, err_cnt=1.
  - N=3 with 1 beat → 1 write, err_cnt+1.
- Bad framing:
  - magic 0x1234, 2 beats → no write, no forward, err_cnt=1.
  - target=7 with NUM_TARGETS=4 → no write, err_cnt+1.
- Idle gaps: tvalid deasserted between CFG beats for 3 cycles → writes occur only on valid beats; addresses stay contiguous.
- Reset mid-CFG: after 1 of 4 writes, assert areset for 1 cycle → all outputs 0. Next 2 stale beats: first fails magic → DROP, err_cnt=1; no writes. A following good packet is written correctly.
